// File: rtl/prefetch_queue_if.sv
// Fetch-bus and decoder-side signals of the instruction prefetch queue.
// master = the prefetch queue itself, slave = the bus/decoder environment.
interface prefetch_queue_if;
    logic         i_flush;
    logic [31:0]  i_flush_ip;
    logic         o_rd;
    logic [31:0]  o_addr;
    logic         i_ack;
    logic [31:0]  i_data;
    logic [127:0] o_codebuf;
    logic [1:0]   o_align;
    logic [31:0]  o_ip;
    logic         o_valid;
    logic         i_consume;
    logic [3:0]   i_len;

    modport master (
        input  i_flush, i_flush_ip, i_ack, i_data, i_consume, i_len,
        output o_rd, o_addr, o_codebuf, o_align, o_ip, o_valid
    );

    modport slave (
        output i_flush, i_flush_ip, i_ack, i_data, i_consume, i_len,
        input  o_rd, o_addr, o_codebuf, o_align, o_ip, o_valid
    );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: circular dword buffer feeding a 4-dword decode window.
// Define PREFETCH_DEPTH16_EN to force a 16-dword queue (default 8).
module prefetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_IP = 32'hFFFF_FFF0
) (
    input  logic             clock,
    input  logic             reset_n,
    prefetch_queue_if.master pq
);
`ifdef PREFETCH_DEPTH16_EN
    localparam int unsigned Q_DEPTH = 16;
`else
    localparam int unsigned Q_DEPTH = DEPTH;
`endif
    localparam int unsigned PTR_W = $clog2(Q_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(Q_DEPTH);
    localparam logic [CNT_W-1:0] WINDOW_C = CNT_W'(4);

    typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_DROP = 1'b1} state_t;

    state_t           state_r, state_nx_s;
    logic             pending_r, pending_nx_s;
    logic [31:0]      req_addr_r, req_addr_nx_s;
    logic [31:0]      fetch_addr_r, fetch_addr_nx_s;
    logic [31:0]      ip_r, ip_nx_s;
    logic [PTR_W-1:0] head_r, head_nx_s;
    logic [PTR_W-1:0] tail_r, tail_nx_s;
    logic [CNT_W-1:0] count_r, count_nx_s;
    logic [31:0]      mem_r [Q_DEPTH];

    logic             ack_s, fetch_ack_s, consume_s, valid_s;
    logic [4:0]       adv_sum_s;
    logic [2:0]       adv_s;
    logic [127:0]     codebuf_s;

    assign valid_s      = (count_r >= WINDOW_C) && (state_r == ST_FETCH);
    assign pq.o_valid   = valid_s;
    assign pq.o_rd      = pending_r;
    assign pq.o_addr    = req_addr_r;
    assign pq.o_ip      = ip_r;
    assign pq.o_align   = ip_r[1:0];
    assign pq.o_codebuf = codebuf_s;

    // Qualify handshakes; a flush discards both acked data and any consume.
    always_comb begin
        ack_s       = pending_r & pq.i_ack;
        fetch_ack_s = ack_s & (state_r == ST_FETCH) & ~pq.i_flush;
        consume_s   = pq.i_consume & valid_s & (pq.i_len != 4'd0) & ~pq.i_flush;
        adv_sum_s   = {3'b000, ip_r[1:0]} + {1'b0, pq.i_len};
        adv_s       = adv_sum_s[4:2];
    end

    // Decode window: four consecutive entries starting at head.
    always_comb begin
        codebuf_s = 128'd0;
        for (int k = 0; k < 4; k++) begin
            codebuf_s[32*k +: 32] = mem_r[head_r + PTR_W'(k)];
        end
    end

    // Next state: a flush that strands an unacked read must swallow its data.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (pq.i_flush && pending_r && !pq.i_ack) begin
                    state_nx_s = ST_DROP;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (ack_s) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_DROP;
                end
            end
            default: state_nx_s = ST_FETCH;
        endcase
    end

    // Read request: the address is latched at issue so it stays stable through a flush.
    always_comb begin
        pending_nx_s  = pending_r;
        req_addr_nx_s = req_addr_r;
        if (ack_s) begin
            pending_nx_s = 1'b0;
        end else if (!pending_r && (state_r == ST_FETCH) && !pq.i_flush && (count_r < DEPTH_C)) begin
            pending_nx_s  = 1'b1;
            req_addr_nx_s = fetch_addr_r;
        end else begin
            pending_nx_s = pending_r;
        end
    end

    // Queue pointers, occupancy, fetch address and instruction pointer.
    always_comb begin
        head_nx_s       = head_r;
        tail_nx_s       = tail_r;
        count_nx_s      = count_r;
        fetch_addr_nx_s = fetch_addr_r;
        ip_nx_s         = ip_r;
        if (pq.i_flush) begin
            head_nx_s       = tail_r;
            count_nx_s      = {CNT_W{1'b0}};
            ip_nx_s         = pq.i_flush_ip;
            fetch_addr_nx_s = {pq.i_flush_ip[31:2], 2'b00};
        end else begin
            if (fetch_ack_s) begin
                tail_nx_s       = tail_r + PTR_W'(1);
                fetch_addr_nx_s = fetch_addr_r + 32'd4;
            end else begin
                tail_nx_s       = tail_r;
                fetch_addr_nx_s = fetch_addr_r;
            end
            if (consume_s) begin
                head_nx_s = head_r + PTR_W'(adv_s);
                ip_nx_s   = ip_r + {28'd0, pq.i_len};
            end else begin
                head_nx_s = head_r;
                ip_nx_s   = ip_r;
            end
            count_nx_s = count_r + CNT_W'(fetch_ack_s)
                         - (consume_s ? CNT_W'(adv_s) : {CNT_W{1'b0}});
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath registers and queue storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_r    <= 1'b0;
            req_addr_r   <= {RESET_IP[31:2], 2'b00};
            fetch_addr_r <= {RESET_IP[31:2], 2'b00};
            ip_r         <= RESET_IP;
            head_r       <= {PTR_W{1'b0}};
            tail_r       <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(Q_DEPTH); i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            pending_r    <= pending_nx_s;
            req_addr_r   <= req_addr_nx_s;
            fetch_addr_r <= fetch_addr_nx_s;
            ip_r         <= ip_nx_s;
            head_r       <= head_nx_s;
            tail_r       <= tail_nx_s;
            count_r      <= count_nx_s;
            if (fetch_ack_s) begin
                mem_r[tail_r] <= pq.i_data;
            end
        end
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// Bench for prefetch_queue: directed sequences, a consume table, and random traffic
// checked each cycle against a queue-based reference model.
module tb_prefetch_queue;
`ifdef PREFETCH_DEPTH16_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 8;
`endif
    localparam logic [31:0] RESET_IP = 32'hFFFF_FFF0;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    prefetch_queue_if pq();
    prefetch_queue #(.DEPTH(8), .RESET_IP(RESET_IP)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .pq     (pq)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: fetched dwords in order, ip, next fetch address, stale-read tracking.
    logic [31:0] mq[$];
    logic [31:0] m_ip, m_fetch, m_drop_addr;
    bit          m_drop;

    typedef struct {
        logic [31:0] start_ip;
        logic [3:0]  len;
        logic [31:0] exp_ip;
        logic [31:0] exp_head;
    } cvec_t;
    cvec_t tbl[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        bit exp_valid;
        exp_valid = (mq.size() >= 4) && !m_drop;
        chk("valid", pq.o_valid, exp_valid);
        chk("ip", pq.o_ip, m_ip);
        chk("align", pq.o_align, m_ip[1:0]);
        if (exp_valid) chk("codebuf", pq.o_codebuf, {mq[3], mq[2], mq[1], mq[0]});
        if (pq.o_rd) chk("addr", pq.o_addr, m_drop ? m_drop_addr : m_fetch);
        if (!m_drop && mq.size() == DEPTH) chk("rd_full", pq.o_rd, 1'b0);
    endtask

    task automatic step(input bit fl, input logic [31:0] fip, input bit ack,
                        input logic [31:0] data, input bit cons, input logic [3:0] len);
        bit rd_pre, ack_eff, valid_m;
        int adv;
        rd_pre  = pq.o_rd;
        ack_eff = ack & rd_pre;
        valid_m = (mq.size() >= 4) && !m_drop;
        pq.i_flush = fl; pq.i_flush_ip = fip; pq.i_ack = ack_eff;
        pq.i_data = data; pq.i_consume = cons; pq.i_len = len;
        @(posedge clock);
        #1;
        if (fl) begin
            if (rd_pre && !ack_eff) begin
                if (!m_drop) m_drop_addr = m_fetch;
                m_drop = 1'b1;
            end else begin
                m_drop = 1'b0;
            end
            mq.delete();
            m_ip    = fip;
            m_fetch = {fip[31:2], 2'b00};
        end else begin
            if (cons && valid_m && len != 4'd0) begin
                adv = (int'(m_ip[1:0]) + int'(len)) / 4;
                repeat (adv) void'(mq.pop_front());
                m_ip = m_ip + {28'd0, len};
            end
            if (ack_eff) begin
                if (m_drop) m_drop = 1'b0;
                else begin
                    mq.push_back(data);
                    m_fetch = m_fetch + 32'd4;
                end
            end
        end
        pq.i_flush = 1'b0; pq.i_ack = 1'b0; pq.i_consume = 1'b0; pq.i_len = 4'd0;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic wait_rd(input int max);
        int n = 0;
        while (!pq.o_rd && n < max) begin
            idle();
            n++;
        end
        chk("rd_wait", pq.o_rd, 1'b1);
    endtask

    // Ack every request with data equal to its address until the model holds n dwords.
    task automatic fill_to(input int n);
        int guard = 0;
        while (mq.size() != n && guard < 400) begin
            step(1'b0, 32'd0, pq.o_rd, pq.o_addr, 1'b0, 4'd0);
            guard++;
        end
        chk("fill_reached", 32'(mq.size()), 32'(n));
    endtask

    initial begin
        logic [127:0] cb;
        logic [31:0]  e;
        tbl[0] = '{32'h0000_1003, 4'd15, 32'h0000_1012, 32'h0000_1010};
        tbl[1] = '{32'h0000_2000, 4'd1,  32'h0000_2001, 32'h0000_2000};
        tbl[2] = '{32'h0000_2002, 4'd2,  32'h0000_2004, 32'h0000_2004};
        tbl[3] = '{32'h0000_3001, 4'd7,  32'h0000_3008, 32'h0000_3008};
        tbl[4] = '{32'h0000_4000, 4'd12, 32'h0000_400C, 32'h0000_400C};
        tbl[5] = '{32'hFFFF_FFFE, 4'd4,  32'h0000_0002, 32'h0000_0000};
        tbl[6] = '{32'h0000_5001, 4'd0,  32'h0000_5001, 32'h0000_5000};

        pq.i_flush = 1'b0; pq.i_flush_ip = 32'd0; pq.i_ack = 1'b0;
        pq.i_data = 32'd0; pq.i_consume = 1'b0; pq.i_len = 4'd0;
        m_ip = RESET_IP; m_fetch = 32'hFFFF_FFF0; m_drop = 1'b0; m_drop_addr = 32'd0;
        reset_n = 1'b0;

        // Reset state
        #12;
        chk("rst_rd", pq.o_rd, 1'b0);
        chk("rst_valid", pq.o_valid, 1'b0);
        chk("rst_ip", pq.o_ip, 32'hFFFF_FFF0);
        chk("rst_addr", pq.o_addr, 32'hFFFF_FFF0);
        chk("rst_codebuf", pq.o_codebuf, 128'd0);
        chk("rst_align", pq.o_align, 2'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rd_first_edge", pq.o_rd, 1'b1);
        chk("addr_first", pq.o_addr, 32'hFFFF_FFF0);

        // No ack: request held indefinitely
        repeat (20) idle();
        chk("noack_rd", pq.o_rd, 1'b1);
        chk("noack_addr", pq.o_addr, 32'hFFFF_FFF0);
        chk("noack_valid", pq.o_valid, 1'b0);
        chk("noack_ip", pq.o_ip, 32'hFFFF_FFF0);

        // Four acks with data = address; o_valid rises after the fourth
        for (int k = 0; k < 4; k++) begin
            wait_rd(8);
            chk("seq_addr", pq.o_addr, 32'hFFFF_FFF0 + 32'(4 * k));
            step(1'b0, 32'd0, 1'b1, pq.o_addr, 1'b0, 4'd0);
            if (k < 3) chk("valid_early", pq.o_valid, 1'b0);
        end
        chk("valid_4th", pq.o_valid, 1'b1);
        chk("codebuf_4", pq.o_codebuf, {32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF4, 32'hFFFF_FFF0});
        wait_rd(8);
        chk("addr_wrap", pq.o_addr, 32'h0000_0000);

        // Full queue stops requesting
        fill_to(DEPTH);
        repeat (5) begin
            idle();
            chk("rd_full_hold", pq.o_rd, 1'b0);
        end

        // Align 3 then consume 15 bytes: advance 4
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd3);
        chk("align3", pq.o_align, 2'd3);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd15);
        chk("c15_ip", pq.o_ip, 32'h0000_0002);
        chk("c15_valid", pq.o_valid, 1'b1);
        chk("c15_codebuf", pq.o_codebuf, {32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000});
        wait_rd(4);

        // Consume table
        for (int i = 0; i < 7; i++) begin
            step(1'b1, tbl[i].start_ip, 1'b0, 32'd0, 1'b0, 4'd0);
            fill_to(DEPTH);
            step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, tbl[i].len);
            e = tbl[i].exp_ip;
            cb = pq.o_codebuf;
            chk("tbl_ip", pq.o_ip, e);
            chk("tbl_align", pq.o_align, e[1:0]);
            chk("tbl_head", cb[31:0], tbl[i].exp_head);
        end

        // Simultaneous ack and consume at count 7
        step(1'b1, 32'h0000_6000, 1'b0, 32'd0, 1'b0, 4'd0);
        fill_to(8);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd4);
        wait_rd(8);
        chk("sim_addr", pq.o_addr, 32'h0000_6020);
        step(1'b0, 32'd0, 1'b1, 32'h0000_6020, 1'b1, 4'd4);
        chk("sim_codebuf", pq.o_codebuf, {32'h0000_6014, 32'h0000_6010, 32'h0000_600C, 32'h0000_6008});
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 4'd12);
        chk("sim_tail", pq.o_codebuf, {32'h0000_6020, 32'h0000_601C, 32'h0000_6018, 32'h0000_6014});
        chk("sim_valid", pq.o_valid, 1'b1);

        // Flush with an unacked read: stale data dropped
        wait_rd(8);
        step(1'b1, 32'h0000_1002, 1'b0, 32'd0, 1'b0, 4'd0);
        chk("drop_valid", pq.o_valid, 1'b0);
        chk("drop_rd", pq.o_rd, 1'b1);
        chk("drop_addr", pq.o_addr, 32'h0000_6024);
        chk("drop_ip", pq.o_ip, 32'h0000_1002);
        chk("drop_align", pq.o_align, 2'd2);
        repeat (3) idle();
        chk("drop_hold", pq.o_addr, 32'h0000_6024);
        step(1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'd0);
        chk("drop_ackgap", pq.o_rd, 1'b0);
        idle();
        chk("drop_newrd", pq.o_rd, 1'b1);
        chk("drop_newaddr", pq.o_addr, 32'h0000_1000);
        fill_to(4);
        cb = pq.o_codebuf;
        chk("drop_discard", cb[31:0], 32'h0000_1000);

        // Flush again while dropping
        wait_rd(8);
        step(1'b1, 32'h0000_3000, 1'b0, 32'd0, 1'b0, 4'd0);
        step(1'b1, 32'h0000_2001, 1'b0, 32'd0, 1'b0, 4'd0);
        chk("dd_ip", pq.o_ip, 32'h0000_2001);
        chk("dd_addr", pq.o_addr, 32'h0000_1010);
        step(1'b0, 32'd0, 1'b1, 32'h1234_5678, 1'b0, 4'd0);
        idle();
        chk("dd_newaddr", pq.o_addr, 32'h0000_2000);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 3), $urandom, ($urandom_range(0, 1) == 1) && pq.o_rd,
                 $urandom, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
